// File: rtl/lrf_pkg.sv
// lrf_pkg: shared pixel width, engine state enum and geometry helpers for lrf_avg_frame
package lrf_pkg;
  localparam int PIXEL_W = 8;
  typedef enum logic {FIRST, RUN} state_t;
  function automatic int sum_w(input int n_win);
    return PIXEL_W + n_win;
  endfunction
  function automatic int beats(input int dim, input int ppb);
    return dim * dim / ppb;
  endfunction
endpackage

// File: rtl/lrf_sum_ram.sv
// lrf_sum_ram: simple dual-port RAM, 1-cycle read with enable (output holds when re=0), one write port
module lrf_sum_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/lrf_avg_frame.sv
// lrf_avg_frame: per-pixel running average over the last 2^N_WIN frames (in: {old,new} pixel beats, out: AXI-S averages, frame_warm, tlast_err); LRF_AVG_ROUND_EN selects round-half-up
module lrf_avg_frame
  import lrf_pkg::*;
#(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM = 512,
  parameter int N_WIN = 4,
  parameter int DATA_WIDTH = 8 * PIXELS_PER_BEAT
) (
  input  logic                    s_axis_aclk,
  input  logic                    s_axis_areset,
  input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    frame_warm,
  output logic                    tlast_err
);
  localparam int SUM_W = sum_w(N_WIN);
  localparam int BEATS = beats(IMAGE_DIM, PIXELS_PER_BEAT);
  localparam int AW = $clog2(BEATS);
  localparam int W = 1 << N_WIN;
  localparam int FW = $clog2(W + 1);
  localparam int RW = PIXELS_PER_BEAT * SUM_W;
  localparam logic [AW-1:0] LAST = AW'(BEATS - 1);
  localparam logic [SUM_W:0] RND = (SUM_W + 1)'((1 << N_WIN) >> 1);
  state_t state, state_n;
  logic [AW-1:0] beat_cnt, s1_addr;
  logic [FW-1:0] frame_cnt;
  logic s1_valid, s1_last, s1_first;
  logic [DATA_WIDTH-1:0] s1_new, s1_old, avg;
  logic [RW-1:0] ram_q, sum_n;
  logic advance, accept, last_beat;
  assign advance = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = ~s1_valid | advance;
  assign accept = s_axis_tvalid & s_axis_tready;
  assign last_beat = beat_cnt == LAST;
  assign frame_warm = frame_cnt == FW'(W);
  always_comb state_n = (accept && last_beat) ? RUN : state;
  lrf_sum_ram #(.DEPTH(BEATS), .WIDTH(RW)) u_ram (
    .clk(s_axis_aclk),
    .re(accept),
    .raddr(beat_cnt),
    .rdata(ram_q),
    .we(s1_valid & advance),
    .waddr(s1_addr),
    .wdata(sum_n)
  );
  for (genvar p = 0; p < PIXELS_PER_BEAT; p++) begin : g_px
    logic [SUM_W-1:0] nv, acc;
    assign nv = SUM_W'(s1_new[p*PIXEL_W +: PIXEL_W]);
    assign acc = s1_first ? nv << N_WIN
                          : ram_q[p*SUM_W +: SUM_W] + nv - SUM_W'(s1_old[p*PIXEL_W +: PIXEL_W]);
    assign sum_n[p*SUM_W +: SUM_W] = acc;
`ifdef LRF_AVG_ROUND_EN
    assign avg[p*PIXEL_W +: PIXEL_W] = PIXEL_W'(({1'b0, acc} + RND) >> N_WIN);
`else
    assign avg[p*PIXEL_W +: PIXEL_W] = PIXEL_W'(acc >> N_WIN);
`endif
  end
  always_ff @(posedge s_axis_aclk) begin
    if (accept) begin
      s1_new <= s_axis_tdata[DATA_WIDTH-1:0];
      s1_old <= s_axis_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
      s1_last <= s_axis_tlast;
      s1_addr <= beat_cnt;
      s1_first <= state == FIRST;
    end
  end
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state <= FIRST;
      beat_cnt <= '0;
      frame_cnt <= '0;
      tlast_err <= 1'b0;
      s1_valid <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      m_axis_tdata <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        frame_cnt <= (last_beat && !frame_warm) ? frame_cnt + 1'b1 : frame_cnt;
        tlast_err <= tlast_err | (s_axis_tlast != last_beat);
      end
      s1_valid <= accept ? 1'b1 : (advance ? 1'b0 : s1_valid);
      if (advance) m_axis_tvalid <= s1_valid;
      if (advance && s1_valid) begin
        m_axis_tdata <= avg;
        m_axis_tlast <= s1_last;
      end
    end
  end
endmodule

// File: tb/tb_lrf_avg_frame.sv
// tb_lrf_avg_frame: randomized and directed stimulus against a per-pixel sum model of lrf_avg_frame
module tb_lrf_avg_frame;
  localparam int PPB = 2;
  localparam int DIM = 4;
  localparam int NW = 2;
  localparam int DW = 8 * PPB;
  localparam int BEATS = DIM * DIM / PPB;
  localparam int W = 1 << NW;
  localparam int SW = 8 + NW;
`ifdef LRF_AVG_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [2*DW-1:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b1;
  logic s_tready, m_tvalid, m_tlast, frame_warm, tlast_err;
  logic [DW-1:0] m_tdata;
  always #5 clk = ~clk;
  lrf_avg_frame #(.PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .N_WIN(NW), .DATA_WIDTH(DW)) dut (
    .s_axis_aclk(clk),
    .s_axis_areset(rst),
    .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .frame_warm(frame_warm),
    .tlast_err(tlast_err)
  );
  int n_vec = 0, n_bad = 0, cyc = 0;
  logic [DW:0] q[$];
  int sums[BEATS][PPB];
  int m_beat = 0, m_frames = 0, acc_edge = -1, fidx = 0;
  bit m_first = 1'b1, m_err = 1'b0, lat_armed = 1'b0, prev_stall = 1'b0, rdy_rand = 1'b0;
  logic [DW:0] prev_out, e;
  logic [DW-1:0] last_out = '0, exp_px;
  logic [DW-1:0] hist[16][BEATS];
  int n, o, s, a;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(posedge clk);
    #1 m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_beat = 0; m_frames = 0; m_first = 1'b1; m_err = 1'b0;
      lat_armed = 1'b1; acc_edge = -1; prev_stall = 1'b0;
    end else begin
      chk("frame_warm", frame_warm, m_frames == W);
      chk("tlast_err", tlast_err, m_err);
      if (prev_stall) begin
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data", {m_tlast, m_tdata}, prev_out);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out = {m_tlast, m_tdata};
      if (m_tvalid && lat_armed) begin
        chk("first_latency", cyc, acc_edge + 1);
        lat_armed = 1'b0;
      end
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = q.pop_front();
          chk("out_beat", {m_tlast, m_tdata}, e);
          last_out = m_tdata;
        end
      end
      if (s_tvalid && s_tready) begin
        if (acc_edge < 0) acc_edge = cyc + 1;
        for (int i = 0; i < PPB; i++) begin
          n = int'(s_tdata[8*i +: 8]);
          o = int'(s_tdata[DW+8*i +: 8]);
          s = m_first ? n * W : (sums[m_beat][i] + n - o + (1 << SW)) % (1 << SW);
          sums[m_beat][i] = s;
          a = ROUND ? (s + W / 2) / W : s / W;
          exp_px[8*i +: 8] = 8'(a);
        end
        q.push_back({s_tlast, exp_px});
        if (s_tlast != (m_beat == BEATS - 1)) m_err = 1'b1;
        if (m_beat == BEATS - 1) begin
          m_beat = 0;
          m_first = 1'b0;
          if (m_frames < W) m_frames++;
        end else m_beat++;
      end
    end
  end
  task automatic send(input int nbeats, input bit rnd, input logic [7:0] nv, input int tl_beat, input int gap_pct);
    logic [DW-1:0] nw, od;
    bit acc;
    int g;
    for (int b = 0; b < nbeats; b++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        s_tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      nw = rnd ? DW'($urandom) : {PPB{nv}};
      od = (fidx == 0) ? DW'($urandom) : (fidx < W ? hist[0][b] : hist[fidx-W][b]);
      if (fidx < 16) hist[fidx][b] = nw;
      s_tdata = {od, nw};
      s_tlast = (tl_beat < 0) ? (b == BEATS - 1) : (b == tl_beat);
      s_tvalid = 1'b1;
      g = 0;
      do begin
        @(negedge clk);
        acc = s_tready;
        @(posedge clk);
        #1;
        g++;
      end while (!acc && g < 100);
      if (!acc) chk("accept_timeout", 0, 1);
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    if (nbeats == BEATS) fidx++;
  endtask
  task automatic drain();
    int g = 0;
    while ((q.size() != 0 || m_tvalid) && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 200) chk("drain_timeout", 0, 1);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    s_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fidx = 0;
  endtask
  task automatic reset_checks();
    @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_frame_warm", frame_warm, 0);
    chk("rst_tlast_err", tlast_err, 0);
    chk("rst_s_tready", s_tready, 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    do_reset();
    reset_checks();
    send(BEATS, 1'b0, 8'd10, -1, 0);
    drain();
    chk("f0_avg", last_out, 16'h0a0a);
    chk("f0_not_warm", frame_warm, 0);
    repeat (3) send(BEATS, 1'b0, 8'd10, -1, 0);
    drain();
    chk("f3_avg", last_out, 16'h0a0a);
    chk("f3_warm", frame_warm, 1);
    send(BEATS, 1'b0, 8'd20, -1, 0);
    drain();
    chk("f4_avg", last_out, ROUND ? 16'h0d0d : 16'h0c0c);
    rdy_rand = 1'b1;
    repeat (6) send(BEATS, 1'b1, 8'd0, -1, 30);
    drain();
    rdy_rand = 1'b0;
    do_reset();
    send(BEATS, 1'b0, 8'd30, 5, 0);
    drain();
    chk("tlast_err_set", tlast_err, 1);
    send(BEATS, 1'b0, 8'd40, -1, 0);
    drain();
    chk("run_after_bad_tlast", last_out, ROUND ? 16'h2121 : 16'h2020);
    chk("tlast_err_sticky", tlast_err, 1);
    do_reset();
    repeat (2) send(BEATS, 1'b0, 8'd5, -1, 0);
    send(3, 1'b0, 8'd5, -1, 0);
    do_reset();
    reset_checks();
    send(BEATS, 1'b0, 8'd50, -1, 0);
    drain();
    chk("mid_rst_first", last_out, 16'h3232);
    send(BEATS, 1'b0, 8'd50, -1, 0);
    drain();
    chk("mid_rst_sum200", last_out, 16'h3232);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
